// File: rtl/enemy_move_sequencer.sv
// Enemy tank move/fire sequencer: commits to a chase direction, detours around blocks, requests fire periodically.
// Latency: move_en/move_dir/fire_req register one cycle after frame_tick; fire_req holds until fire_ack (no other backpressure).
module enemy_move_sequencer #(
    parameter int unsigned HOLD_FRAMES   = 16,
    parameter int unsigned DETOUR_FRAMES = 8,
    parameter int unsigned FIRE_PERIOD   = 60,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       frame_tick,
    input  logic [1:0] chase_dir,
    input  logic       blocked,
    input  logic       fire_ack,
    output logic [1:0] move_dir,
    output logic       move_en,
    output logic       fire_req,
    output logic [1:0] state_dbg
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CHASE  = 2'd1;
    localparam logic [1:0] ST_DETOUR = 2'd2;

    localparam logic [7:0] HOLD_RELOAD   = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0] DETOUR_RELOAD = 8'(DETOUR_FRAMES - 1);
    localparam logic [7:0] FIRE_LAST     = 8'(FIRE_PERIOD - 1);

    logic [1:0]  state, state_nxt;
    logic [1:0]  dir_nxt;
    logic        move_en_nxt;
    logic [7:0]  hold_cnt, hold_nxt;
    logic [7:0]  detour_cnt, detour_nxt;
    logic        blk_cnt, blk_nxt;
    logic [7:0]  fire_cnt, fire_cnt_nxt;
    logic        fire_req_nxt;
    logic [15:0] lfsr, lfsr_nxt;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    assign state_dbg = state;

    always_comb begin
        state_nxt   = state;
        dir_nxt     = move_dir;
        move_en_nxt = 1'b0;
        hold_nxt    = hold_cnt;
        detour_nxt  = detour_cnt;
        blk_nxt     = blk_cnt;
        if (!enable) begin
            state_nxt  = ST_IDLE;
            hold_nxt   = 8'd0;
            detour_nxt = 8'd0;
            blk_nxt    = 1'b0;
        end else if (frame_tick) begin
            case (state)
                ST_IDLE: begin
                    dir_nxt   = chase_dir;
                    hold_nxt  = HOLD_RELOAD;
                    state_nxt = ST_CHASE;
                end
                ST_CHASE: begin
                    if (blocked) begin
                        // Turn perpendicular; lfsr picks which side.
                        dir_nxt    = {~move_dir[1], lfsr[0]};
                        detour_nxt = DETOUR_RELOAD;
                        blk_nxt    = 1'b0;
                        state_nxt  = ST_DETOUR;
                    end else begin
                        move_en_nxt = 1'b1;
                        if (hold_cnt != 8'd0) begin
                            hold_nxt = hold_cnt - 8'd1;
                        end else begin
                            dir_nxt  = chase_dir;
                            hold_nxt = HOLD_RELOAD;
                        end
                    end
                end
                ST_DETOUR: begin
                    if (blocked) begin
                        dir_nxt = move_dir ^ 2'b01;
                        if (!blk_cnt) begin
                            blk_nxt = 1'b1;
                        end else begin
                            // Both perpendicular sides walled off: give up on the detour.
                            blk_nxt   = 1'b0;
                            hold_nxt  = HOLD_RELOAD;
                            state_nxt = ST_CHASE;
                        end
                    end else begin
                        move_en_nxt = 1'b1;
                        blk_nxt     = 1'b0;
                        if (detour_cnt == 8'd0) begin
                            dir_nxt   = chase_dir;
                            hold_nxt  = HOLD_RELOAD;
                            state_nxt = ST_CHASE;
                        end else begin
                            detour_nxt = detour_cnt - 8'd1;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        fire_req_nxt = fire_req;
        fire_cnt_nxt = fire_cnt;
        if (!enable) begin
            fire_req_nxt = 1'b0;
            fire_cnt_nxt = 8'd0;
        end else if (fire_req) begin
            // Count frozen while a request is outstanding, including on an ack+tick cycle.
            if (fire_ack) begin
                fire_req_nxt = 1'b0;
            end
        end else if (frame_tick && (state == ST_CHASE || state == ST_DETOUR)) begin
            if (fire_cnt == FIRE_LAST) begin
                fire_req_nxt = 1'b1;
                fire_cnt_nxt = 8'd0;
            end else begin
                fire_cnt_nxt = fire_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            move_dir   <= 2'd0;
            move_en    <= 1'b0;
            fire_req   <= 1'b0;
            hold_cnt   <= 8'd0;
            detour_cnt <= 8'd0;
            blk_cnt    <= 1'b0;
            fire_cnt   <= 8'd0;
            lfsr       <= LFSR_SEED;
        end else begin
            state      <= state_nxt;
            move_dir   <= dir_nxt;
            move_en    <= move_en_nxt;
            fire_req   <= fire_req_nxt;
            hold_cnt   <= hold_nxt;
            detour_cnt <= detour_nxt;
            blk_cnt    <= blk_nxt;
            fire_cnt   <= fire_cnt_nxt;
            lfsr       <= lfsr_nxt;
        end
    end

endmodule
